// File: rtl/ram_stream_reader_pkg.sv
// rtl/ram_stream_reader_pkg.sv - state encoding and FIFO depth legality check for ram_stream_reader
package ram_stream_reader_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // Four entries cover the read round trip, so the credit loop never starves a ready sink.
  localparam int MIN_FIFO_DEPTH = 4;

  function automatic bit fifo_depth_legal(input int depth);
    return (depth >= MIN_FIFO_DEPTH) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/ram_stream_fifo.sv
// rtl/ram_stream_fifo.sv - synchronous show-ahead FIFO with occupancy count, zero head when empty
module ram_stream_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_rd;

  assign empty   = (count == '0);
  assign do_rd   = rd_en && !empty;
  // Head is forced to zero when empty so stream outputs read as 0 with tvalid low.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy tracking; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the empty gate hides stale contents.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // The upstream credit loop must never push into a full FIFO.
  always_ff @(posedge clk) begin
    if (resetn) assert (!(wr_en && !do_rd && (count == CW'(DEPTH))));
  end

endmodule

// File: rtl/ram_stream_reader.sv
// rtl/ram_stream_reader.sv - streams a block of RAM words as AXI-Stream; RAM_STREAM_READER_SOF_EN adds mAxisTuser
module ram_stream_reader
  import ram_stream_reader_pkg::*;
#(
  parameter int MEM_WIDTH  = 16,
  parameter int MEM_SIZE   = 13,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [MEM_SIZE-1:0]  startAddr,
  input  logic [MEM_SIZE:0]    length,
  output logic                 busy,
  output logic                 done,
  output logic                 readCs,
  output logic [MEM_SIZE-1:0]  readAddr,
  input  logic [MEM_WIDTH-1:0] readData,
  output logic                 mAxisTvalid,
  input  logic                 mAxisTready,
  output logic [MEM_WIDTH-1:0] mAxisTdata,
  output logic                 mAxisTlast
`ifdef RAM_STREAM_READER_SOF_EN
  ,
  output logic                 mAxisTuser
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
`ifdef RAM_STREAM_READER_SOF_EN
  localparam int FW = MEM_WIDTH + 2;
`else
  localparam int FW = MEM_WIDTH + 1;
`endif

  if (!fifo_depth_legal(FIFO_DEPTH)) begin : g_bad_depth
    $error("ram_stream_reader: FIFO_DEPTH must be a power of two and at least 4");
  end

  logic [1:0]          state;
  logic [MEM_SIZE:0]   len_q;
  logic [MEM_SIZE:0]   issued;
  logic                in_flight;
  logic                rd_last;
  logic                rd_first;
  logic                last_issue;
  logic                handshake;
  logic [CW:0]         occupancy;
  logic [CW-1:0]       fifo_count;
  logic                fifo_empty;
  logic [FW-1:0]       fifo_wdata;
  logic [FW-1:0]       fifo_rdata;

  // A read is only issued when its word is guaranteed a FIFO slot on return.
  assign occupancy   = {1'b0, fifo_count} + (CW+1)'(in_flight);
  assign readCs      = (state == ST_ISSUE) && (occupancy < (CW+1)'(FIFO_DEPTH));
  assign last_issue  = (issued + (MEM_SIZE+1)'(1)) == len_q;
  assign busy        = (state != ST_IDLE);
  assign handshake   = mAxisTvalid && mAxisTready;

  assign mAxisTvalid = !fifo_empty;
  assign mAxisTdata  = fifo_rdata[MEM_WIDTH-1:0];
  assign mAxisTlast  = fifo_rdata[MEM_WIDTH];
`ifdef RAM_STREAM_READER_SOF_EN
  assign mAxisTuser  = fifo_rdata[MEM_WIDTH+1];
  assign fifo_wdata  = {rd_first, rd_last, readData};
`else
  assign fifo_wdata  = {rd_last, readData};
`endif

  // Command FSM with address/issue counters; done pulses one cycle after completion.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      len_q    <= '0;
      issued   <= '0;
      readAddr <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (length == '0) begin
              done <= 1'b1;
            end else begin
              state    <= ST_ISSUE;
              len_q    <= length;
              issued   <= '0;
              readAddr <= startAddr;
            end
          end
        end
        ST_ISSUE: begin
          if (readCs) begin
            readAddr <= readAddr + MEM_SIZE'(1);
            issued   <= issued + (MEM_SIZE+1)'(1);
            if (last_issue) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (handshake && mAxisTlast) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Tag each returning word with its last/first markers in step with the RAM latency.
  always_ff @(posedge clk) begin
    if (!reset) begin
      in_flight <= 1'b0;
      rd_last   <= 1'b0;
      rd_first  <= 1'b0;
    end else begin
      in_flight <= readCs;
      rd_last   <= readCs && last_issue;
      rd_first  <= readCs && (issued == '0);
    end
  end

  ram_stream_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (reset),
    .wr_en   (in_flight),
    .wr_data (fifo_wdata),
    .rd_en   (handshake),
    .rd_data (fifo_rdata),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_ram_stream_reader.sv
// tb/tb_ram_stream_reader.sv - self-checking bench for ram_stream_reader with behavioural RAM and scoreboard
`timescale 1ns/1ps
module tb_ram_stream_reader;

  localparam int MW = 16;
  localparam int MS = 13;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [MS-1:0] startAddr = '0;
  logic [MS:0]   length = '0;
  logic          busy, done, readCs;
  logic [MS-1:0] readAddr;
  logic [MW-1:0] readData;
  logic          mAxisTvalid;
  logic          mAxisTready = 1'b0;
  logic [MW-1:0] mAxisTdata;
  logic          mAxisTlast;
`ifdef RAM_STREAM_READER_SOF_EN
  logic          mAxisTuser;
`endif

  ram_stream_reader #(.MEM_WIDTH(MW), .MEM_SIZE(MS), .FIFO_DEPTH(FD)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .startAddr   (startAddr),
    .length      (length),
    .busy        (busy),
    .done        (done),
    .readCs      (readCs),
    .readAddr    (readAddr),
    .readData    (readData),
    .mAxisTvalid (mAxisTvalid),
    .mAxisTready (mAxisTready),
    .mAxisTdata  (mAxisTdata),
    .mAxisTlast  (mAxisTlast)
`ifdef RAM_STREAM_READER_SOF_EN
    ,
    .mAxisTuser  (mAxisTuser)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [MW-1:0] ram [2**MS];
  always @(posedge clk) if (readCs) readData <= ram[readAddr];

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [MW-1:0] data;
    logic          last;
    logic          first;
  } beat_t;
  beat_t exp_q[$];

  int beats, first_valid_cyc, last_cyc, done_cnt, rdcs_cnt, valid_cnt;
  int model_issued = 0, model_popped = 0;
  logic          prev_stall = 1'b0;
  logic [MW-1:0] prev_data;
  logic          prev_last;
  logic          rand_rdy = 1'b0;

  always @(posedge clk) begin
    #1;
    if (rand_rdy) mAxisTready = 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    if (!reset) begin
      model_issued = 0;
      model_popped = 0;
      prev_stall   = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", mAxisTvalid, 1);
        check("stall_data", mAxisTdata, prev_data);
        check("stall_last", mAxisTlast, prev_last);
      end
      if (readCs) begin
        check("credit", (model_issued - model_popped) < FD, 1);
        rdcs_cnt++;
      end
      if (mAxisTvalid) begin
        valid_cnt++;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      if (done) done_cnt++;
      if (mAxisTvalid && mAxisTready) begin
        beats++;
        check("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat_data", mAxisTdata, e.data);
          check("beat_last", mAxisTlast, e.last);
`ifdef RAM_STREAM_READER_SOF_EN
          check("beat_tuser", mAxisTuser, e.first);
`endif
        end
        if (mAxisTlast) last_cyc = cyc;
        model_popped++;
      end
      if (readCs) model_issued++;
      prev_stall = mAxisTvalid && !mAxisTready;
      prev_data  = mAxisTdata;
      prev_last  = mAxisTlast;
    end
  end

  task automatic clear_markers();
    beats = 0; first_valid_cyc = -1; last_cyc = -1;
    done_cnt = 0; rdcs_cnt = 0; valid_cnt = 0;
  endtask

  task automatic push_exp(input int a, input int len);
    for (int i = 0; i < len; i++) begin
      beat_t e;
      logic [MS-1:0] ad;
      ad = MS'(a + i);
      e.data = MW'(ad);
      e.last = (i == len - 1);
      e.first = (i == 0);
      exp_q.push_back(e);
    end
  endtask

  // Called at posedge+1: drives start for cycle 0 and returns in cycle 1.
  task automatic issue_cmd(input int a, input int len, output int t0);
    t0 = cyc;
    startAddr = MS'(a);
    length = (MS+1)'(len);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int at);
    int n;
    n = 0;
    at = -1;
    while (n < budget) begin
      @(posedge clk); #1;
      n++;
      if (done) begin
        at = cyc;
        break;
      end
    end
    check("done_timeout", at >= 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, dc, n;
    for (int i = 0; i < 2**MS; i++) ram[i] = MW'(i);

    // reset state
    idle(3);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_readcs", readCs, 0);
    check("rst_tvalid", mAxisTvalid, 0);
    check("rst_tlast", mAxisTlast, 0);
    check("rst_tdata", mAxisTdata, 0);
    check("rst_readaddr", readAddr, 0);
    reset = 1'b1;
    idle(2);

    // 1: basic latency and throughput
    clear_markers(); mAxisTready = 1'b1;
    push_exp('h10, 8);
    issue_cmd('h10, 8, t0);
    check("t1_busy_c1", busy, 1);
    check("t1_readcs_c1", readCs, 1);
    check("t1_addr_c1", readAddr, 'h10);
    wait_done(40, dc);
    check("t1_first_valid_cyc", first_valid_cyc - t0, 3);
    check("t1_last_cyc", last_cyc - t0, 10);
    check("t1_done_cyc", dc - t0, 11);
    check("t1_busy_at_done", busy, 0);
    idle(1);
    check("t1_done_width", done, 0);
    check("t1_beats", beats, 8);
    check("t1_sb_empty", exp_q.size(), 0);

    // 2: address wrap
    clear_markers();
    push_exp(2**MS - 2, 4);
    issue_cmd(2**MS - 2, 4, t0);
    wait_done(40, dc);
    idle(2);
    check("t2_beats", beats, 4);
    check("t2_sb_empty", exp_q.size(), 0);
    check("t2_done_cnt", done_cnt, 1);

    // 3: random backpressure
    clear_markers();
    push_exp('h100, 16);
    rand_rdy = 1'b1;
    issue_cmd('h100, 16, t0);
    wait_done(400, dc);
    rand_rdy = 1'b0;
    mAxisTready = 1'b1;
    idle(2);
    check("t3_beats", beats, 16);
    check("t3_sb_empty", exp_q.size(), 0);
    check("t3_readcs_cnt", rdcs_cnt, 16);

    // 4a: zero-length command
    clear_markers();
    issue_cmd('h55, 0, t0);
    check("t4_busy_c1", busy, 0);
    check("t4_done_c1", done, 1);
    check("t4_readcs_c1", readCs, 0);
    idle(1);
    check("t4_done_c2", done, 0);
    idle(3);
    check("t4_no_readcs", rdcs_cnt, 0);
    check("t4_no_tvalid", valid_cnt, 0);
    check("t4_done_cnt", done_cnt, 1);

    // 4b: start while busy is ignored
    clear_markers();
    push_exp('h40, 4);
    issue_cmd('h40, 4, t0);
    startAddr = MS'('h500); length = (MS+1)'(8); start = 1'b1;
    idle(1);
    start = 1'b0;
    wait_done(40, dc);
    idle(4);
    check("t4b_beats", beats, 4);
    check("t4b_done_cnt", done_cnt, 1);
    check("t4b_readcs_cnt", rdcs_cnt, 4);
    check("t4b_sb_empty", exp_q.size(), 0);

    // 5: reset mid-transfer with the sink stalled
    clear_markers();
    push_exp('h200, 32);
    issue_cmd('h200, 32, t0);
    n = 0;
    while (beats < 4 && n < 40) begin @(posedge clk); #1; n++; end
    check("t5_beat_timeout", beats >= 4, 1);
    mAxisTready = 1'b0;
    idle(3);
    reset = 1'b0;
    idle(1);
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_readcs", readCs, 0);
    check("t5_tvalid", mAxisTvalid, 0);
    check("t5_tlast", mAxisTlast, 0);
    check("t5_tdata", mAxisTdata, 0);
    check("t5_readaddr", readAddr, 0);
    exp_q.delete();
    reset = 1'b1;
    idle(1);
    clear_markers();
    mAxisTready = 1'b1;
    push_exp('h30, 2);
    issue_cmd('h30, 2, t0);
    wait_done(40, dc);
    idle(3);
    check("t5_post_beats", beats, 2);
    check("t5_post_readcs", rdcs_cnt, 2);
    check("t5_post_sb_empty", exp_q.size(), 0);

    // 6: back-to-back commands, second start on the done cycle
    clear_markers();
    push_exp('h60, 3);
    push_exp('h70, 3);
    issue_cmd('h60, 3, t0);
    wait_done(40, dc);
    issue_cmd('h70, 3, t1);
    check("t6_busy_second", busy, 1);
    wait_done(40, dc);
    check("t6_done_cyc", dc - t1, 6);
    idle(3);
    check("t6_beats", beats, 6);
    check("t6_done_cnt", done_cnt, 2);
    check("t6_sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
